// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed display digit scanner.
// Sequences NUM_DIGITS digits, each holding its cathode enable for DWELL_CYCLES and then
// keeping all cathodes off for BLANK_CYCLES (anti-ghosting gap). Only digits with their
// digit_mask bit set are visited. frame_done pulses when the scan wraps back to a lower
// or equal digit index.
// Optional feature macro: SCAN_BRIGHTNESS_EN adds a 4-bit brightness input that shortens
// the lit portion of each dwell without changing the dwell length.
// Ports:
//   slow_clock  in   clock, rising edge
//   reset       in   synchronous, active-high
//   enable      in   1 = scan runs, 0 = stop with all cathodes off
//   digit_mask  in   bit k = 1 -> digit k is scanned
//   brightness  in   (SCAN_BRIGHTNESS_EN only) lit fraction of dwell, (brightness+1)/16
//   SEL         out  index of current digit
//   CAT         out  one-hot cathode enable, SEL=k -> CAT[NUM_DIGITS-1-k]
//   blank       out  1 whenever CAT == 0
//   frame_done  out  one-cycle pulse when the scan wraps
module digit_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 8,
  localparam int unsigned SEL_W       = $clog2(NUM_DIGITS)
) (
  input  logic                  slow_clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_DIGITS-1:0] digit_mask,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [3:0]            brightness,
`endif
  output logic [SEL_W-1:0]      SEL,
  output logic [NUM_DIGITS-1:0] CAT,
  output logic                  blank,
  output logic                  frame_done
);

  localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [NUM_DIGITS-1:0] cat_q, cat_d;
  logic                  blank_q, blank_d;
  logic                  fd_q, fd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [SEL_W-1:0]      low_c;
  logic [SEL_W-1:0]      hi_c;
  logic                  hi_found_c;
  logic                  mask_nz_c;
  logic                  adv_c;

`ifdef SCAN_BRIGHTNESS_EN
  logic [CNT_W-1:0]      on_q, on_d;
  logic [CNT_W-1:0]      on_calc_c;
  int unsigned           on_prod_c;

  // Lit cycles per dwell: max(1, (brightness+1)*DWELL_CYCLES/16).
  always_comb begin
    on_prod_c = ((32'(brightness) + 32'd1) * DWELL_CYCLES) >> 4;
    if (on_prod_c == 32'd0) begin
      on_prod_c = 32'd1;
    end
    on_calc_c = CNT_W'(on_prod_c);
  end
`endif

  // One-hot cathode for a digit index; digit 0 drives the MSB.
  function automatic logic [NUM_DIGITS-1:0] cat_for(input logic [SEL_W-1:0] s);
    logic [NUM_DIGITS-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (s == SEL_W'(k)) begin
        v[NUM_DIGITS-1-k] = 1'b1;
      end
    end
    return v;
  endfunction

  // Lowest enabled digit, and lowest enabled digit strictly above the current one.
  always_comb begin
    low_c      = '0;
    hi_c       = '0;
    hi_found_c = 1'b0;
    mask_nz_c  = |digit_mask;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (digit_mask[i]) begin
        low_c = SEL_W'(i);
        if (i > int'(sel_q)) begin
          hi_c       = SEL_W'(i);
          hi_found_c = 1'b1;
        end
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cat_d   = cat_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    adv_c   = 1'b0;
`ifdef SCAN_BRIGHTNESS_EN
    on_d    = on_q;
`endif

    unique case (state_q)
      IDLE: begin
        cat_d = '0;
        cnt_d = '0;
        if (enable && mask_nz_c) begin
          state_d = DWELL;
          sel_d   = low_c;
          cat_d   = cat_for(low_c);
`ifdef SCAN_BRIGHTNESS_EN
          on_d    = on_calc_c;
`endif
        end
      end

      DWELL: begin
        if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
          cnt_d = '0;
          if (BLANK_CYCLES == 0) begin
            adv_c = 1'b1;
          end else begin
            state_d = BLANK;
            cat_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SCAN_BRIGHTNESS_EN
          // Cathode stays lit while the upcoming dwell cycle index is below the lit count.
          cat_d = ((32'(cnt_q) + 32'd1) < 32'(on_q)) ? cat_for(sel_q) : '0;
`else
          cat_d = cat_for(sel_q);
`endif
        end
      end

      BLANK: begin
        cat_d = '0;
        if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
          cnt_d = '0;
          adv_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cat_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // End of a digit period: the mask is sampled here only.
    if (adv_c) begin
      if (!mask_nz_c) begin
        state_d = IDLE;
        cat_d   = '0;
      end else begin
        state_d = DWELL;
        sel_d   = hi_found_c ? hi_c : low_c;
        cat_d   = cat_for(hi_found_c ? hi_c : low_c);
        fd_d    = !hi_found_c;
`ifdef SCAN_BRIGHTNESS_EN
        on_d    = on_calc_c;
`endif
      end
    end

    // Stop overrides everything except reset; SEL is kept.
    if (!enable) begin
      state_d = IDLE;
      sel_d   = sel_q;
      cat_d   = '0;
      cnt_d   = '0;
      fd_d    = 1'b0;
    end

    blank_d = (cat_d == '0);
  end

  // State and output registers.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cat_q   <= '0;
      blank_q <= 1'b1;
      fd_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef SCAN_BRIGHTNESS_EN
      on_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cat_q   <= cat_d;
      blank_q <= blank_d;
      fd_q    <= fd_d;
      cnt_q   <= cnt_d;
`ifdef SCAN_BRIGHTNESS_EN
      on_q    <= on_d;
`endif
    end
  end

  assign SEL        = sel_q;
  assign CAT        = cat_q;
  assign blank      = blank_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Testbench for digit_scan_ctrl (NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2).
// The reference model tracks the running digit and its position inside the digit period.
module tb_digit_scan_ctrl;

  localparam int N      = 4;
  localparam int DW     = 4;
  localparam int BL     = 2;
  localparam int PERIOD = DW + BL;

  logic       slow_clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] digit_mask;
  logic [3:0] m_b;
  logic [1:0] SEL;
  logic [3:0] CAT;
  logic       blank;
  logic       frame_done;

  always #5 slow_clock = ~slow_clock;

  digit_scan_ctrl #(
    .NUM_DIGITS  (N),
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .slow_clock(slow_clock),
    .reset     (reset),
    .enable    (enable),
    .digit_mask(digit_mask),
`ifdef SCAN_BRIGHTNESS_EN
    .brightness(m_b),
`endif
    .SEL       (SEL),
    .CAT       (CAT),
    .blank     (blank),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] cat;
    logic       blank;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  // Reference model state.
  bit m_run = 1'b0;
  int m_cur = 0;
  int m_pos = 0;
  int m_on  = DW;

  function automatic int on_for(input logic [3:0] b);
    int v;
`ifdef SCAN_BRIGHTNESS_EN
    v = ((int'(b) + 1) * DW) / 16;
`else
    // Without the brightness feature a digit is lit for the whole dwell (full brightness).
    v = ((int'(b | 4'hF) + 1) * DW) / 16;
`endif
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < N; i++) if (m[i]) return i;
    return 0;
  endfunction

  // Issue one cycle of stimulus and queue the response expected after the next edge.
  task automatic cyc(input bit r, input bit e, input logic [3:0] m, input logic [3:0] b);
    exp_t       x;
    logic [3:0] c;
    int         nx;
    reset      = r;
    enable     = e;
    digit_mask = m;
    m_b        = b;
    x.fd       = 1'b0;
    if (r) begin
      m_run = 1'b0;
      m_cur = 0;
      m_pos = 0;
    end else if (!e) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (m != 4'b0) begin
        m_run = 1'b1;
        m_cur = lowest(m);
        m_pos = 0;
        m_on  = on_for(b);
      end
    end else begin
      m_pos++;
      if (m_pos == PERIOD) begin
        m_pos = 0;
        if (m == 4'b0) begin
          m_run = 1'b0;
        end else begin
          nx = m_cur;
          for (int k = 1; k <= N; k++) begin
            if (m[(m_cur + k) % N]) begin
              nx = (m_cur + k) % N;
              break;
            end
          end
          x.fd  = (nx <= m_cur);
          m_cur = nx;
          m_on  = on_for(b);
        end
      end
    end
    c = 4'b1000;
    c = c >> m_cur;
    x.cat   = (m_run && m_pos < m_on) ? c : 4'b0000;
    x.sel   = 2'(m_cur);
    x.blank = (x.cat == 4'b0000);
    exp_q.push_back(x);
    @(posedge slow_clock);
    #2;
  endtask

  // Monitor: the DUT presents a fresh output every cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge slow_clock);
      cyc_no++;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_cmp++;
        if ({SEL, CAT, blank, frame_done} !== x) begin
          n_bad++;
          $display("FAIL scan_out cycle %0d: got sel=%0d cat=%b blank=%b fd=%b, expected sel=%0d cat=%b blank=%b fd=%b",
                   cyc_no, SEL, CAT, blank, frame_done, x.sel, x.cat, x.blank, x.fd);
        end
      end
    end
  end

  initial begin
    logic [3:0] rm;
    logic [3:0] rb;
    bit         rr;
    bit         re;

    // Reset with arbitrary inputs.
    cyc(1'b1, 1'b1, 4'b1011, 4'h3);
    cyc(1'b1, 1'b0, 4'b1111, 4'h9);

    // Full scan of four digits.
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, 4'b1111, 4'hF);

    // Sparse mask.
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 4'b0101, 4'hF);

    // Single digit.
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 4'b0010, 4'hF);

    // Restart from reset, stop during second dwell cycle of digit 1, then re-enable.
    cyc(1'b1, 1'b0, 4'b1111, 4'hF);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 4'b1111, 4'hF);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b1111, 4'hF);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 4'b1111, 4'hF);
    // Mask cleared mid-dwell: digit finishes, then idle.
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 4'b0000, 4'hF);

    // Reset pulsed during the blank after digit 2, then resume.
    cyc(1'b1, 1'b0, 4'b1111, 4'hF);
    for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 4'b1111, 4'hF);
    cyc(1'b1, 1'b1, 4'b1111, 4'hF);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 4'b1111, 4'hF);

    // Fixed brightness levels (full lit time when the feature is absent).
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 4'b1001, 4'h7);
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b1, 4'b1001, 4'h0);

    // Randomized run.
    rm = 4'hF;
    rb = 4'hF;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) rm = 4'($urandom);
      if ($urandom_range(0, 99) < 5) rb = 4'($urandom);
      rr = ($urandom_range(0, 199) == 0);
      re = ($urandom_range(0, 99) >= 3);
      cyc(rr, re, rm, rb);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge slow_clock);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
